// File: rtl/cpu_pkg.sv
// Shared datapath types: divider FSM state encoding and iteration-count helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // One restoring step per quotient bit.
  function automatic int div_iters(input int width);
    return width;
  endfunction

  localparam int DIV_ITERS = div_iters(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;

  // rem < divisor <= 2^(WIDTH-1), so the shifted remainder always fits WIDTH bits.
  assign rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div.sv
// Sequential signed divider (MIPS DIV semantics): lo = quotient toward zero, hi = remainder.
module div
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             div_control,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             operando,
  output logic             fim,
  output logic             div_zero,
  output div_state_t       state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(div_iters(WIDTH) - 1);

  div_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic             sign_q, sign_r;
  logic             start_ok, start_zero;

  // Two's-complement magnitude; the most negative value maps onto itself, read as unsigned.
  assign x_mag = x[WIDTH-1] ? -x : x;
  assign y_mag = y[WIDTH-1] ? -y : y;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    case (state)
      IDLE: begin
        if (div_control) begin
          if (y == '0) begin
            start_zero = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = ITER;
          end
        end
      end
      ITER:    if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      operando <= 1'b0;
      fim      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      fim <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            quo      <= x_mag;
            divisor  <= y_mag;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= x[WIDTH-1] ^ y[WIDTH-1];
            sign_r   <= x[WIDTH-1];
            operando <= 1'b1;
            div_zero <= 1'b0;
          end else if (start_zero) begin
            div_zero <= 1'b1;
            fim      <= 1'b1;
          end
        end
        ITER: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          lo       <= sign_q ? -quo : quo;
          hi       <= sign_r ? -rem : rem;
          operando <= 1'b0;
          fim      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table, randomized model checks and multi-cycle corner sequences.
module tb_div;
  import cpu_pkg::*;

  localparam int W = 32;
  localparam int LAT = 33;
  localparam int BOUND = 60;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] x, y, hi, lo;
  logic         div_control;
  logic         operando, fim, div_zero;
  div_state_t   state;

  int errors = 0;
  int checks = 0;

  // Expected {div_zero, hi, lo} per fim pulse.
  logic [2*W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[13];

  div #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .div_control (div_control),
    .hi          (hi),
    .lo          (lo),
    .operando    (operando),
    .fim         (fim),
    .div_zero    (div_zero),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every fim pulse pops one expectation.
  always @(negedge clk) begin
    if (reset && fim) begin
      if (exp_q.size() == 0) check("spurious_fim", 96'(fim), 96'd0);
      else check("result", 96'({div_zero, hi, lo}), 96'(exp_q.pop_front()));
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                        input bit scramble);
    int n;
    int opn;
    int exp_lat;
    exp_lat = edz ? 0 : LAT;
    @(negedge clk);
    x = a;
    y = b;
    div_control = 1'b1;
    exp_q.push_back({edz, eh, el});
    @(posedge clk);
    @(negedge clk);
    if (!scramble) div_control = 1'b0;
    n = 0;
    opn = 0;
    while (!fim && n < BOUND) begin
      if (operando) opn++;
      if (scramble) begin
        x = $urandom;
        y = $urandom;
      end
      @(negedge clk);
      n++;
    end
    div_control = 1'b0;
    check("latency", 96'(n), 96'(exp_lat));
    check("operando_cycles", 96'(opn), 96'(exp_lat));
    if (n >= BOUND) exp_q.delete();
    @(negedge clk);
    check("fim_pulse", 96'(fim), 96'd0);
  endtask

  initial begin
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[1]  = '{-32'sd100,      32'd7,          -32'sd2,        32'hFFFF_FFF2,  1'b0};
    vecs[2]  = '{32'd100,        -32'sd7,        32'd2,          -32'sd14,       1'b0};
    vecs[3]  = '{-32'sd100,      -32'sd7,        -32'sd2,        32'd14,         1'b0};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[5]  = '{32'h8000_0000,  32'd1,          32'd0,          32'h8000_0000,  1'b0};
    vecs[6]  = '{32'd5,          32'd9,          32'd5,          32'd0,          1'b0};
    vecs[7]  = '{32'd1234,       32'd0,          32'd5,          32'd0,          1'b1};
    vecs[8]  = '{32'd0,          32'd3,          32'd0,          32'd0,          1'b0};
    vecs[9]  = '{-32'sd5,        32'd9,          -32'sd5,        32'd0,          1'b0};
    vecs[10] = '{32'd7,          32'd7,          32'd0,          32'd1,          1'b0};
    vecs[11] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[12] = '{32'h8000_0000,  32'h8000_0000,  32'd0,          32'd1,          1'b0};

    reset = 1'b0;
    x = '0;
    y = '0;
    div_control = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 96'({operando, fim, div_zero, hi, lo}), 96'd0);
    check("reset_state", 96'(state), 96'(IDLE));
    reset = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].x, vecs[i].y, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, 1'b0);

    // Randomized operands against the language's truncating signed division.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      if (rb == '0) rb = 32'd3;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'h7FFF_FFFF;
      sa = ra;
      sb = rb;
      run_op(ra, rb, sa % sb, sa / sb, 1'b0, 1'b0);
    end

    // Start request held and operands scrambled while busy: original result, no restart.
    run_op(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    x = 32'd100;
    y = 32'd7;
    div_control = 1'b1;
    exp_q.push_back({1'b0, 32'd2, 32'd14});
    @(posedge clk);
    @(negedge clk);
    div_control = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_op_busy", 96'(operando), 96'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", 96'({operando, fim, div_zero, hi, lo}), 96'd0);
    check("async_reset_state", 96'(state), 96'(IDLE));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    check("hold_hi_lo", 96'({hi, lo}), 96'({32'd0, 32'd10}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
